seq_mult_ctrl: RTL and testbench

//  Controller and accumulator for the 8x8 sequential multiplier. Sequences one shared 16-bit

---
 rtl/seq_mult_ctrl.sv | 100 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add sequencer for a WIDTH x WIDTH unsigned multiply that drives one external
// PW-bit adder; latches operands on start and holds the product after a one-cycle done strobe.
module seq_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa_in,
  input  logic [WIDTH-1:0]     datab_in,
  output logic [2*WIDTH-1:0]   add_dataa,
  output logic [2*WIDTH-1:0]   add_datab,
  input  logic [2*WIDTH-1:0]   add_sum,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_out
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state_q,   state_d;
  logic [PW-1:0]      acc_q,     acc_d;
  logic [PW-1:0]      mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [PW-1:0]      product_q, product_d;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    add_dataa = '0;
    add_datab = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, dataa_in};
          mplier_d = datab_in;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        busy      = 1'b1;
        add_dataa = acc_q;
        // Partial product for multiplier bit count_q; bits shifted past PW-1 fall off.
        add_datab = mplier_q[count_q] ? (mcand_q << count_q) : '0;
        acc_d     = add_sum;
        count_d   = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = add_sum;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product   = product_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: behavioural adder on the add_* ports, table vectors, random
// operands checked against a*b, and hand sequences for held start, busy start and reset abort.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa_in, datab_in;
  logic [15:0] add_dataa, add_datab, add_sum, product;
  logic        busy, done;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] step_b[$];

  seq_mult_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset_a(reset_a), .start(start),
    .dataa_in(dataa_in), .datab_in(datab_in),
    .add_dataa(add_dataa), .add_datab(add_datab), .add_sum(add_sum),
    .product(product), .busy(busy), .done(done), .state_out(state_out)
  );

  assign add_sum = add_dataa + add_datab;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation starting from IDLE. inj>0 pulses start with other operands at that
  // cycle; rst_at>0 asserts reset at that cycle and aborts. lat counts edges from acceptance.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int inj, input int rst_at,
                       output logic [15:0] prod, output int lat, output int busy_n,
                       output logic aborted);
    prod = '0; lat = -1; busy_n = 0; aborted = 1'b0;
    step_b.delete();
    @(negedge clk);
    start = 1'b1; dataa_in = a; datab_in = b;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; dataa_in = 8'($urandom); datab_in = 8'($urandom);
      end
      if (busy) busy_n++;
      if (state_out == 2'b01) step_b.push_back(add_datab);
      if (done) begin
        lat = k - 1; prod = product;
        break;
      end
      if (k == inj) begin
        start = 1'b1; dataa_in = ~a; datab_in = ~b;
      end
      if (k == inj + 1) start = 1'b0;
      if (k == rst_at) begin
        reset_a = 1'b1;
        #1;
        chk("abort state_out", 32'(state_out), 32'd0);
        chk("abort product", 32'(product), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        aborted = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_check(input logic [7:0] a, input logic [7:0] b, input string name);
    logic [15:0] prod, exp;
    int lat, busy_n, bad;
    logic aborted;
    exp = 16'(a) * 16'(b);
    do_op(a, b, 0, 0, prod, lat, busy_n, aborted);
    chk({name, " product"}, 32'(prod), 32'(exp));
    chk({name, " latency"}, 32'(lat), 32'd8);
    chk({name, " busy cycles"}, 32'(busy_n), 32'd9);
    // Each CALC step adds a<<i exactly when bit i of b is set.
    bad = (step_b.size() == 8) ? 0 : 1;
    for (int i = 0; i < step_b.size() && i < 8; i++)
      if (step_b[i] !== (b[i] ? (16'(a) << i) : 16'h0)) bad++;
    chk({name, " add_datab steps"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({name, " done one cycle"}, 32'(done), 32'd0);
    chk({name, " idle after"}, {busy, state_out}, 32'd0);
    @(negedge clk);
    chk({name, " product held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] prod;
    int lat, busy_n, ndone, last_done;
    logic aborted;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h0F, 8'h68, 16'h0618, "t1 0Fx68"};
    vecs[1] = '{8'h3C, 8'h48, 16'h10E0, "t2 3Cx48"};
    vecs[2] = '{8'h00, 8'h0F, 16'h0000, "t2 00x0F"};
    vecs[3] = '{8'hFF, 8'hFF, 16'hFE01, "t3 FFxFF"};
    vecs[4] = '{8'h01, 8'h80, 16'h0080, "t3 01x80"};

    reset_a = 1'b1; start = 1'b0; dataa_in = '0; datab_in = '0;
    repeat (2) @(negedge clk);
    chk("reset state_out", 32'(state_out), 32'd0);
    chk("reset busy/done", {busy, done}, 32'd0);
    chk("reset product", 32'(product), 32'd0);
    chk("reset adder ops", {add_dataa, add_datab}, 32'd0);
    reset_a = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      chk({vecs[i].name, " table model"}, 32'(16'(vecs[i].a) * 16'(vecs[i].b)), 32'(vecs[i].exp));
      run_check(vecs[i].a, vecs[i].b, vecs[i].name);
      chk({vecs[i].name, " table product"}, 32'(product), 32'(vecs[i].exp));
    end

    for (int r = 0; r < 20; r++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run_check(ra, rb, "random");
    end

    // Start held high: a result every WIDTH+2 cycles; operand noise during CALC is ignored.
    ndone = 0; last_done = 0;
    @(negedge clk);
    start = 1'b1; dataa_in = 8'h03; datab_in = 8'h05;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        chk("t4 product", 32'(product), 32'h000F);
        if (ndone > 0) chk("t4 interval", 32'(k - last_done), 32'd10);
        ndone++; last_done = k;
        dataa_in = 8'h03; datab_in = 8'h05;
      end else if (state_out == 2'b01) begin
        dataa_in = 8'($urandom); datab_in = 8'($urandom);
      end
    end
    chk("t4 done count", 32'(ndone), 32'd4);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Start pulsed during CALC with other operands is ignored.
    do_op(8'h2B, 8'h1D, 3, 0, prod, lat, busy_n, aborted);
    chk("t5 product", 32'(prod), 32'(16'h2B * 16'h1D));
    chk("t5 latency", 32'(lat), 32'd8);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5 no second done", 32'(ndone), 32'd0);

    // Reset mid-CALC (count=4) aborts; a restart then works.
    run_check(8'h11, 8'h22, "t6 pre");
    do_op(8'h55, 8'h66, 0, 5, prod, lat, busy_n, aborted);
    chk("t6 aborted", 32'(aborted), 32'd1);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6 no done after abort", 32'(ndone), 32'd0);
    chk("t6 product cleared", 32'(product), 32'd0);
    run_check(8'h55, 8'h66, "t6 restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
